ma_stage_ctrl: RTL and testbench

- Memory-access stage controller. Sits on the output side of the EX/MA pipeline register and consumes its Result, Inst, Operand_B and Inst_Type values.
- Performs loads and stores to data memory over a req/ready handshake. Stalls the upstream pipeline while an access is outstanding.
- Presents registered results to the MA/WB register.

---
 rtl/ma_stage_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_ma_stage_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ma_stage_ctrl.sv
// Memory-access stage controller: issues loads/stores over a req/ready handshake,
// stalls upstream while an access is outstanding, and registers results for MA/WB.
module ma_stage_ctrl #(
    parameter logic [4:0]  LOAD_TYPE  = 5'd3,
    parameter logic [4:0]  STORE_TYPE = 5'd4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Result_In,
    input  logic [31:0] Inst_In,
    input  logic [4:0]  Inst_Type_In,
    input  logic [31:0] Operand_B_In,
    output logic        Stall_Out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] Result_Out,
    output logic [31:0] Inst_Out,
    output logic [4:0]  Inst_Type_Out,
    output logic        Valid_Out,
    output logic        Misalign_Out,
    output logic        Bus_Err_Out
);

    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, data_q, inst_q;
    logic [4:0]    type_q;
    logic [2:0]    size_q;
    logic          store_q;
    logic          latch;

    logic [31:0] res_d, inst_d;
    logic [4:0]  type_d;
    logic        valid_d, mis_d, err_d;

    logic        in_mem, in_mis;
    logic [31:0] lane, load_val, acc_wdata;
    logic [3:0]  acc_be;

    // Size code bits [1:0]: 00 byte, 01 half, anything else is a word access.
    always_comb begin
        in_mem = ((Inst_Type_In == LOAD_TYPE) || (Inst_Type_In == STORE_TYPE)) && (Inst_In != '0);
        unique case (Inst_In[13:12])
            2'b00:   in_mis = 1'b0;
            2'b01:   in_mis = Result_In[0];
            default: in_mis = (Result_In[1:0] != 2'b00);
        endcase
    end

    always_comb begin
        lane = mem_rdata >> {addr_q[1:0], 3'b000};
        case (size_q)
            3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_val = {24'd0, lane[7:0]};
            3'b101:  load_val = {16'd0, lane[15:0]};
            default: load_val = lane;
        endcase
        unique case (size_q[1:0])
            2'b00: begin
                acc_be    = 4'b0001 << addr_q[1:0];
                acc_wdata = {4{data_q[7:0]}};
            end
            2'b01: begin
                acc_be    = 4'b0011 << addr_q[1:0];
                acc_wdata = {2{data_q[15:0]}};
            end
            default: begin
                acc_be    = 4'b1111;
                acc_wdata = data_q;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch     = 1'b0;
        res_d     = Result_Out;
        inst_d    = Inst_Out;
        type_d    = Inst_Type_Out;
        valid_d   = 1'b0;
        mis_d     = 1'b0;
        err_d     = 1'b0;
        Stall_Out = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (in_mem && !in_mis) begin
                    Stall_Out = 1'b1;
                    latch     = 1'b1;
                    cnt_d     = '0;
                    state_d   = ACCESS;
                end else begin
                    inst_d  = Inst_In;
                    type_d  = Inst_Type_In;
                    valid_d = (Inst_In != '0);
                    mis_d   = in_mem;
                    res_d   = in_mem ? '0 : Result_In;
                end
            end
            ACCESS: begin
                mem_req   = 1'b1;
                mem_we    = store_q;
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_be    = acc_be;
                mem_wdata = store_q ? acc_wdata : '0;
                // Ready wins over the timeout in the final counted cycle.
                if (mem_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                    inst_d  = inst_q;
                    type_d  = type_q;
                    res_d   = store_q ? addr_q : load_val;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                    inst_d  = inst_q;
                    type_d  = type_q;
                    res_d   = '0;
                end else begin
                    Stall_Out = 1'b1;
                    cnt_d     = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            inst_q        <= '0;
            type_q        <= '0;
            size_q        <= '0;
            store_q       <= 1'b0;
            Result_Out    <= '0;
            Inst_Out      <= '0;
            Inst_Type_Out <= '0;
            Valid_Out     <= 1'b0;
            Misalign_Out  <= 1'b0;
            Bus_Err_Out   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            Result_Out    <= res_d;
            Inst_Out      <= inst_d;
            Inst_Type_Out <= type_d;
            Valid_Out     <= valid_d;
            Misalign_Out  <= mis_d;
            Bus_Err_Out   <= err_d;
            if (latch) begin
                addr_q  <= Result_In;
                data_q  <= Operand_B_In;
                inst_q  <= Inst_In;
                type_q  <= Inst_Type_In;
                size_q  <= Inst_In[14:12];
                store_q <= (Inst_Type_In == STORE_TYPE);
            end
        end
    end

endmodule

// File: tb/tb_ma_stage_ctrl.sv
// Bench for ma_stage_ctrl: directed vector table, reset corner sequences and
// randomized operations checked against a byte-level behavioural model.
module tb_ma_stage_ctrl;

    localparam int unsigned TO = 16;
    localparam logic [4:0]  LT = 5'd3;
    localparam logic [4:0]  ST = 5'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Result_In, Inst_In, Operand_B_In, mem_rdata;
    logic [4:0]  Inst_Type_In;
    logic        mem_ready;
    logic        Stall_Out, mem_req, mem_we, Valid_Out, Misalign_Out, Bus_Err_Out;
    logic [31:0] mem_addr, mem_wdata, Result_Out, Inst_Out;
    logic [3:0]  mem_be;
    logic [4:0]  Inst_Type_Out;

    always #5 clk = ~clk;

    ma_stage_ctrl #(.LOAD_TYPE(LT), .STORE_TYPE(ST), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .Result_In(Result_In), .Inst_In(Inst_In), .Inst_Type_In(Inst_Type_In),
        .Operand_B_In(Operand_B_In), .Stall_Out(Stall_Out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .Result_Out(Result_Out), .Inst_Out(Inst_Out), .Inst_Type_Out(Inst_Type_Out),
        .Valid_Out(Valid_Out), .Misalign_Out(Misalign_Out), .Bus_Err_Out(Bus_Err_Out)
    );

    typedef struct {
        logic [31:0] inst;
        logic [4:0]  typ;
        logic [31:0] addr;
        logic [31:0] b;
        logic [31:0] rdata;
        int          delay;
        logic        e_valid;
        logic [31:0] e_res;
        logic        e_mis;
        logic        e_err;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        int          e_stall;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkv(input logic [31:0] inst, input logic [4:0] typ,
                                 input logic [31:0] addr, input logic [31:0] b,
                                 input logic [31:0] rdata, input int delay,
                                 input logic e_valid, input logic [31:0] e_res,
                                 input logic e_mis, input logic e_err, input logic [3:0] e_be,
                                 input logic [31:0] e_wdata, input int e_stall);
        vec_t v;
        v.inst = inst; v.typ = typ; v.addr = addr; v.b = b; v.rdata = rdata; v.delay = delay;
        v.e_valid = e_valid; v.e_res = e_res; v.e_mis = e_mis; v.e_err = e_err;
        v.e_be = e_be; v.e_wdata = e_wdata; v.e_stall = e_stall;
        return v;
    endfunction

    // Reference: access width in bytes, alignment by modulo, lanes assembled byte by byte.
    function automatic vec_t model(input logic [31:0] inst, input logic [4:0] typ,
                                   input logic [31:0] addr, input logic [31:0] b,
                                   input logic [31:0] rdata, input int delay);
        vec_t        v;
        int          nb, off;
        logic [2:0]  f3;
        logic [31:0] byt;
        logic [63:0] val;
        v = mkv(inst, typ, addr, b, rdata, delay, 1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 0);
        f3  = inst[14:12];
        nb  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        off = int'(addr % 4);
        if (!((typ == LT || typ == ST) && inst != 0)) begin
            v.e_valid = (inst != 0);
            v.e_res   = addr;
            return v;
        end
        v.e_valid = 1'b1;
        if (int'(addr % nb) != 0) begin
            v.e_mis = 1'b1;
            return v;
        end
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + nb) v.e_be[i] = 1'b1;
            byt = (b >> (8 * (i % nb))) & 32'hFF;
            v.e_wdata = v.e_wdata | (byt << (8 * i));
        end
        v.e_stall = ((delay < int'(TO) - 1) ? delay : int'(TO) - 1) + 1;
        if (delay >= int'(TO)) begin
            v.e_err = 1'b1;
        end else if (typ == ST) begin
            v.e_res = addr;
        end else begin
            val = 64'd0;
            for (int j = 0; j < nb; j++) begin
                byt = (rdata >> (8 * (off + j))) & 32'hFF;
                val = val | (64'(byt) << (8 * j));
            end
            if (f3[2] == 1'b0 && nb < 4 && val >= (64'd1 << (8 * nb - 1)))
                val = val - (64'd1 << (8 * nb));
            v.e_res = val[31:0];
        end
        return v;
    endfunction

    task automatic apply(input vec_t v);
        int   stalls;
        logic st;
        st = (v.typ == ST);
        Inst_In = v.inst; Inst_Type_In = v.typ; Result_In = v.addr; Operand_B_In = v.b;
        mem_ready = 1'b0; mem_rdata = $urandom;
        #1;
        chk("stall_idle", 32'(Stall_Out), 32'(v.e_stall > 0));
        chk("req_idle", 32'(mem_req), 32'd0);
        stalls = int'(Stall_Out);
        if (v.e_stall > 0) begin
            for (int k = 0; k < int'(TO); k++) begin
                step();
                mem_ready = (k == v.delay);
                mem_rdata = mem_ready ? v.rdata : $urandom;
                #1;
                chk("req_acc", 32'(mem_req), 32'd1);
                chk("we_acc", 32'(mem_we), 32'(st));
                chk("addr_acc", mem_addr, v.addr & ~32'd3);
                chk("be_acc", 32'(mem_be), 32'(v.e_be));
                if (st) chk("wdata_acc", mem_wdata, v.e_wdata);
                chk("valid_acc", 32'(Valid_Out), 32'd0);
                stalls += int'(Stall_Out);
                if (mem_ready || k == int'(TO) - 1) break;
            end
            chk("stall_cycles", 32'(stalls), 32'(v.e_stall));
        end
        step();
        mem_ready = 1'b0;
        chk("valid_ret", 32'(Valid_Out), 32'(v.e_valid));
        chk("req_ret", 32'(mem_req), 32'd0);
        if (v.e_valid) begin
            chk("result", Result_Out, v.e_res);
            chk("inst_out", Inst_Out, v.inst);
            chk("type_out", 32'(Inst_Type_Out), 32'(v.typ));
            chk("misalign", 32'(Misalign_Out), 32'(v.e_mis));
            chk("bus_err", 32'(Bus_Err_Out), 32'(v.e_err));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; Result_In = '0; Inst_In = '0; Inst_Type_In = '0; Operand_B_In = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        step();
        step();
        chk("rst_valid", 32'(Valid_Out), 32'd0);
        chk("rst_result", Result_Out, 32'd0);
        chk("rst_inst", Inst_Out, 32'd0);
        chk("rst_type", 32'(Inst_Type_Out), 32'd0);
        chk("rst_flags", 32'({Misalign_Out, Bus_Err_Out}), 32'd0);
        chk("rst_req_stall", 32'({mem_req, Stall_Out}), 32'd0);
        rst = 1'b0;

        tbl.push_back(mkv(32'h002081B3, 5'd0, 32'h42, 0, 0, 0, 1, 32'h42, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(32'h00000003, LT, 32'h1003, 0, 32'h80000000, 0, 1, 32'hFFFFFF80, 0, 0, 4'b1000, 0, 1));
        tbl.push_back(mkv(32'h00004003, LT, 32'h1003, 0, 32'h80000000, 0, 1, 32'h00000080, 0, 0, 4'b1000, 0, 1));
        tbl.push_back(mkv(32'h00001023, ST, 32'h2002, 32'h1234ABCD, 0, 3, 1, 32'h2002, 0, 0, 4'b1100, 32'hABCDABCD, 4));
        tbl.push_back(mkv(32'h00002003, LT, 32'h3001, 0, 0, 0, 1, 32'h0, 1, 0, 0, 0, 0));
        tbl.push_back(mkv(32'h00002003, LT, 32'h4000, 0, 32'h5555AAAA, TO + 5, 1, 32'h0, 0, 1, 4'b1111, 0, TO));
        tbl.push_back(mkv(32'h00A00093, 5'd0, 32'hCAFE0001, 0, 0, 0, 1, 32'hCAFE0001, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(32'h00001003, LT, 32'h6, 0, 32'h80011234, 1, 1, 32'hFFFF8001, 0, 0, 4'b1100, 0, 2));
        tbl.push_back(mkv(32'h00005003, LT, 32'h10, 0, 32'h1234F00D, 2, 1, 32'h0000F00D, 0, 0, 4'b0011, 0, 3));
        tbl.push_back(mkv(32'h00000023, ST, 32'h5, 32'h11223377, 0, 0, 1, 32'h5, 0, 0, 4'b0010, 32'h77777777, 1));
        tbl.push_back(mkv(32'h00002023, ST, 32'h8, 32'hDEADBEEF, 0, 0, 1, 32'h8, 0, 0, 4'b1111, 32'hDEADBEEF, 1));
        tbl.push_back(mkv(32'h00000000, LT, 32'h100, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(32'h00001023, ST, 32'h11, 32'h1, 0, 0, 1, 32'h0, 1, 0, 0, 0, 0));
        tbl.push_back(mkv(32'h00003003, LT, 32'h2, 0, 0, 0, 1, 32'h0, 1, 0, 0, 0, 0));
        tbl.push_back(mkv(32'h00002003, LT, 32'hC, 0, 32'h01020304, TO - 1, 1, 32'h01020304, 0, 0, 4'b1111, 0, TO));
        tbl.push_back(mkv(32'h00000007, 5'd7, 32'h7, 0, 0, 0, 1, 32'h7, 0, 0, 0, 0, 0));
        foreach (tbl[i]) apply(tbl[i]);

        // Reset during the second ACCESS cycle of a store; a late ready must be ignored.
        Inst_In = 32'h00002023; Inst_Type_In = ST; Result_In = 32'h40; Operand_B_In = 32'h11111111;
        mem_ready = 1'b0;
        step();
        step();
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0; Inst_In = '0; Inst_Type_In = '0; Result_In = '0; mem_ready = 1'b1;
        #1;
        chk("arst_req", 32'(mem_req), 32'd0);
        chk("arst_stall", 32'(Stall_Out), 32'd0);
        chk("arst_valid", 32'(Valid_Out), 32'd0);
        chk("arst_result", Result_Out, 32'd0);
        chk("arst_inst", Inst_Out, 32'd0);
        chk("arst_flags", 32'({Misalign_Out, Bus_Err_Out}), 32'd0);
        step();
        chk("late_ready_valid", 32'(Valid_Out), 32'd0);
        chk("late_ready_req", 32'(mem_req), 32'd0);
        mem_ready = 1'b0;
        apply(mkv(32'h002081B3, 5'd0, 32'h99, 0, 0, 0, 1, 32'h99, 0, 0, 0, 0, 0));

        for (int n = 0; n < 80; n++) begin
            logic [31:0] inst, addr;
            logic [4:0]  typ;
            int          d, r;
            r    = int'($urandom_range(0, 9));
            typ  = (r < 4) ? LT : (r < 7) ? ST : 5'($urandom_range(0, 31));
            inst = $urandom;
            if ($urandom_range(0, 9) == 0) inst = '0;
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr = addr & ~32'd3;
            d = int'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) d = int'(TO) - 1 + int'($urandom_range(0, 2));
            apply(model(inst, typ, addr, $urandom, $urandom, d));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
